// File: rtl/pipe_reg_file.sv
// Multi-port register file with destination scoreboard (busy bits + registered busy count).
// Optional write-through forwarding on the read ports: define PIPE_REG_FILE_BYPASS_EN.
module pipe_reg_file #(
    parameter int unsigned DATA_W   = 32'd32,
    parameter int unsigned ADDR_W   = 32'd5,
    parameter int unsigned NUM_RD   = 32'd2,
    parameter int unsigned ZERO_REG = 32'd1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_enable,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_addr,
    output logic [ADDR_W:0]            busy_count
);

    localparam int unsigned DEPTH     = 32'd1 << ADDR_W;
    localparam logic        ZERO_EN_C = (ZERO_REG != 32'd0);

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [ADDR_W:0]   busy_count_r;

    logic              wr_ok_s;
    logic              iss_ok_s;
    logic [DEPTH-1:0]  wr_mask_s;
    logic [DEPTH-1:0]  iss_mask_s;
    logic [DEPTH-1:0]  busy_next_s;
    logic [NUM_RD*DATA_W-1:0] rd_data_s;
    logic [NUM_RD-1:0]        rd_busy_s;

    function automatic logic [ADDR_W:0] popcount_f(input logic [DEPTH-1:0] vec);
        logic [ADDR_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            cnt = cnt + {{ADDR_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // Qualify write/issue (register 0 is hardwired when enabled) and form the next busy vector.
    always_comb begin
        wr_ok_s     = wr_enable   && !(ZERO_EN_C && (wr_addr    == {ADDR_W{1'b0}}));
        iss_ok_s    = issue_valid && !(ZERO_EN_C && (issue_addr == {ADDR_W{1'b0}}));
        wr_mask_s   = wr_ok_s  ? ({{(DEPTH-1){1'b0}}, 1'b1} << wr_addr)    : {DEPTH{1'b0}};
        iss_mask_s  = iss_ok_s ? ({{(DEPTH-1){1'b0}}, 1'b1} << issue_addr) : {DEPTH{1'b0}};
        // Set after clear: a same-edge issue marks a newer pending producer.
        busy_next_s = (busy_r & ~wr_mask_s) | iss_mask_s;
    end

    // Register array storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // Scoreboard busy bits and their registered population count.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r       <= {DEPTH{1'b0}};
            busy_count_r <= {(ADDR_W+1){1'b0}};
        end else begin
            busy_r       <= busy_next_s;
            busy_count_r <= popcount_f(busy_next_s);
        end
    end

    // Combinational read ports, each resolved independently.
    always_comb begin
        rd_data_s = {(NUM_RD*DATA_W){1'b0}};
        rd_busy_s = {NUM_RD{1'b0}};
        for (int k = 0; k < int'(NUM_RD); k++) begin
            logic [ADDR_W-1:0] ra;
            logic              wr_hit;
            ra     = rd_addr[k*ADDR_W +: ADDR_W];
            wr_hit = wr_ok_s && (wr_addr == ra);
            if (ZERO_EN_C && (ra == {ADDR_W{1'b0}})) begin
                rd_data_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                rd_busy_s[k]                  = 1'b0;
            end else begin
`ifdef PIPE_REG_FILE_BYPASS_EN
                if (wr_hit) begin
                    rd_data_s[k*DATA_W +: DATA_W] = wr_data;
                    rd_busy_s[k]                  = 1'b0;
                end else begin
                    rd_data_s[k*DATA_W +: DATA_W] = regs_r[ra];
                    rd_busy_s[k]                  = busy_r[ra];
                end
`else
                // Without forwarding, an in-flight write to this address makes the old data stale.
                rd_data_s[k*DATA_W +: DATA_W] = regs_r[ra];
                rd_busy_s[k]                  = busy_r[ra] | wr_hit;
`endif
            end
        end
    end

    assign rd_data    = rd_data_s;
    assign rd_busy    = rd_busy_s;
    assign busy_count = busy_count_r;

endmodule

// File: tb/tb_pipe_reg_file.sv
// Self-checking bench for pipe_reg_file: directed literal checks plus randomized traffic
// compared every cycle against an array-based model of the register file and scoreboard.
module tb_pipe_reg_file;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_enable = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic [5:0]  busy_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_regs [32];
    logic        m_busy [32];

    pipe_reg_file dut (
        .clock       (clock),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_enable   (wr_enable),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .busy_count  (busy_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    // Expected view of one read port given the model state and this cycle's write.
    function automatic void expect_port(input logic [4:0] a, output logic [31:0] d, output logic b);
        if (a == 5'd0) begin
            d = 32'd0; b = 1'b0;
        end else if (wr_enable && wr_addr == a) begin
`ifdef PIPE_REG_FILE_BYPASS_EN
            d = wr_data; b = 1'b0;
`else
            d = m_regs[a]; b = 1'b1;
`endif
        end else begin
            d = m_regs[a]; b = m_busy[a];
        end
    endfunction

    // Model update: reset clears everything; write clears busy, issue sets it afterwards.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= 32'd0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            if (wr_enable && wr_addr != 5'd0) begin
                m_regs[wr_addr] <= wr_data;
                m_busy[wr_addr] <= 1'b0;
            end
            if (issue_valid && issue_addr != 5'd0) m_busy[issue_addr] <= 1'b1;
        end
    end

    // Compare process.
    always @(negedge clock) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                logic [31:0] d;
                logic        b;
                expect_port(rd_addr[k*5 +: 5], d, b);
                check($sformatf("model_rd_data%0d", k), {32'd0, rd_data[k*32 +: 32]}, {32'd0, d});
                check($sformatf("model_rd_busy%0d", k), {63'd0, rd_busy[k]}, {63'd0, b});
            end
            check("model_busy_count", {58'd0, busy_count}, 64'(model_count()));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_enable = 1'b0; issue_valid = 1'b0;
    endtask

    initial begin
        // Two reset cycles.
        tick(); tick();
        reset = 1'b0;

        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            @(negedge clock);
            check("rst_rd_data", {32'd0, rd_data[31:0]} | {32'd0, rd_data[63:32]}, 64'd0);
            check("rst_rd_busy", {62'd0, rd_busy}, 64'd0);
            check("rst_busy_count", {58'd0, busy_count}, 64'd0);
            tick();
        end

        // Write r5 while reading it.
        rd_addr = {5'd0, 5'd5};
        wr_enable = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        @(negedge clock);
`ifdef PIPE_REG_FILE_BYPASS_EN
        check("wr_same_cycle_data", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);
        check("wr_same_cycle_busy", {63'd0, rd_busy[0]}, 64'd0);
`else
        check("wr_same_cycle_data", {32'd0, rd_data[31:0]}, 64'd0);
        check("wr_same_cycle_busy", {63'd0, rd_busy[0]}, 64'd1);
`endif
        tick(); idle();
        @(negedge clock);
        check("wr_next_cycle_data", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);
        tick();

        // Issue r7 then r9, then retire r7.
        issue_valid = 1'b1; issue_addr = 5'd7;
        tick();
        issue_addr = 5'd9; rd_addr = {5'd9, 5'd7};
        @(negedge clock);
        check("issue_count1", {58'd0, busy_count}, 64'd1);
        check("issue_r7_busy", {63'd0, rd_busy[0]}, 64'd1);
        tick(); idle();
        @(negedge clock);
        check("issue_count2", {58'd0, busy_count}, 64'd2);
        check("issue_r9_busy", {63'd0, rd_busy[1]}, 64'd1);
        wr_enable = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0077;
        tick(); idle();
        @(negedge clock);
        check("retire_count", {58'd0, busy_count}, 64'd1);
        check("retire_r7_busy", {63'd0, rd_busy[0]}, 64'd0);

        // r3 already busy, then same-edge issue + write to r3.
        issue_valid = 1'b1; issue_addr = 5'd3;
        tick();
        wr_enable = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_1234;
        tick(); idle();
        rd_addr = {5'd9, 5'd3};
        @(negedge clock);
        check("same_edge_data", {32'd0, rd_data[31:0]}, 64'h1234);
        check("same_edge_busy", {63'd0, rd_busy[0]}, 64'd1);
        check("same_edge_count", {58'd0, busy_count}, 64'd2);
        tick();

        // Register 0 ignores writes and issues.
        rd_addr = {5'd0, 5'd0};
        wr_enable = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        issue_valid = 1'b1; issue_addr = 5'd0;
        @(negedge clock);
        check("r0_data_same", {32'd0, rd_data[31:0]}, 64'd0);
        check("r0_busy_same", {63'd0, rd_busy[0]}, 64'd0);
        tick(); idle();
        @(negedge clock);
        check("r0_data", {32'd0, rd_data[63:32]}, 64'd0);
        check("r0_busy", {62'd0, rd_busy}, 64'd0);
        check("r0_count", {58'd0, busy_count}, 64'd2);
        tick();

        // Fill the scoreboard, then reset mid-operation.
        for (int a = 1; a < 32; a++) begin
            issue_valid = 1'b1; issue_addr = 5'(a);
            tick();
        end
        idle();
        @(negedge clock);
        check("full_count", {58'd0, busy_count}, 64'd31);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 32; a += 4) begin
            rd_addr = {5'(a + 1), 5'(a)};
            @(negedge clock);
            check("post_rst_count", {58'd0, busy_count}, 64'd0);
            check("post_rst_data", rd_data, 64'd0);
            check("post_rst_busy", {62'd0, rd_busy}, 64'd0);
            tick();
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] lo;
            reset       = ($urandom_range(0, 127) == 0);
            wr_enable   = $urandom_range(0, 1) == 1;
            issue_valid = $urandom_range(0, 2) != 0;
            lo          = 5'($urandom_range(0, 7));
            wr_addr     = ($urandom_range(0, 1) == 1) ? lo : 5'($urandom_range(0, 31));
            issue_addr  = ($urandom_range(0, 1) == 1) ? wr_addr : 5'($urandom_range(0, 31));
            wr_data     = $urandom;
            rd_addr[4:0] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr[9:5] = ($urandom_range(0, 2) == 0) ? rd_addr[4:0] : 5'($urandom_range(0, 15));
            tick();
        end
        reset = 1'b0; idle();
        @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
